// File: rtl/ov7670_capture_if.sv
// Pixel stream from the OV7670 capture stage to the frame-buffer writer.
// The capture block drives the master side; the writer uses the slave side.
interface ov7670_capture_if;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic [9:0]  pix_x;
   logic [8:0]  pix_y;
   logic        frame_start;
   logic        frame_done;
   logic        line_err;

   modport master (output pix_data, pix_valid, pix_x, pix_y, frame_start, frame_done, line_err);
   modport slave  (input  pix_data, pix_valid, pix_x, pix_y, frame_start, frame_done, line_err);
endinterface

// File: rtl/ov7670_capture.sv
// OV7670 RGB565 capture: waits for init_done, drops settling frames, then packs byte pairs into pixels.
// Define OV7670_CAPTURE_DECIMATE_EN to accept only every other frame after settling.
module ov7670_capture #(
   parameter int H_ACTIVE      = 640,
   parameter int V_ACTIVE      = 480,
   parameter int SETTLE_FRAMES = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      init_done,
   input  logic                      vsync,
   input  logic                      href,
   input  logic [7:0]                din,
   ov7670_capture_if.master          pix
);

   localparam int SW = (SETTLE_FRAMES > 0) ? $clog2(SETTLE_FRAMES + 1) : 1;

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_WAIT_VS, S_ACTIVE} state_t;

   state_t         state_q, state_d;
   logic           vsync_d, href_d;
   logic           vs_rise, vs_fall, href_fall;
   logic [SW-1:0]  settle_cnt;
   logic           dec_skip;
   logic           start_set, done_set, capture_en;
   logic           phase, x_ovf;
   logic [7:0]     hi_byte;
   logic [9:0]     x_cnt;
   logic [8:0]     y_cnt;
   logic           x_full, y_full;

   assign vs_rise   = vsync & ~vsync_d;
   assign vs_fall   = ~vsync & vsync_d;
   assign href_fall = ~href & href_d;
   assign x_full    = (x_cnt == 10'(H_ACTIVE));
   assign y_full    = (y_cnt == 9'(V_ACTIVE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d <= 1'b0;
         href_d  <= 1'b0;
      end else begin
         vsync_d <= vsync;
         href_d  <= href;
      end
   end

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state; losing init_done overrides everything
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (init_done) state_d = S_SETTLE;
         S_SETTLE:  if (settle_cnt == SW'(SETTLE_FRAMES)) state_d = S_WAIT_VS;
         S_WAIT_VS: if (vs_fall && !dec_skip) state_d = S_ACTIVE;
         S_ACTIVE:  if (vs_rise) state_d = S_WAIT_VS;
         default:   state_d = S_IDLE;
      endcase
      if (!init_done) state_d = S_IDLE;
   end

   // FSM: decoded controls for the datapath
   always_comb begin
      start_set  = 1'b0;
      done_set   = 1'b0;
      capture_en = 1'b0;
      if (state_q == S_WAIT_VS && state_d == S_ACTIVE) start_set = 1'b1;
      if (state_q == S_ACTIVE  && state_d == S_WAIT_VS) done_set = 1'b1;
      if (state_q == S_ACTIVE  && state_d == S_ACTIVE)  capture_en = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         settle_cnt <= '0;
      else if (state_q != S_SETTLE)
         settle_cnt <= '0;
      else if (vs_rise && settle_cnt != SW'(SETTLE_FRAMES))
         settle_cnt <= settle_cnt + SW'(1);
   end

`ifdef OV7670_CAPTURE_DECIMATE_EN
   // Toggles on every frame boundary seen while waiting, so the first post-settle frame is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         dec_skip <= 1'b0;
      else if (state_q == S_IDLE || state_q == S_SETTLE)
         dec_skip <= 1'b0;
      else if (state_q == S_WAIT_VS && vs_fall && init_done)
         dec_skip <= ~dec_skip;
   end
`else
   assign dec_skip = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix.pix_data    <= '0;
         pix.pix_valid   <= 1'b0;
         pix.pix_x       <= '0;
         pix.pix_y       <= '0;
         pix.frame_start <= 1'b0;
         pix.frame_done  <= 1'b0;
         pix.line_err    <= 1'b0;
         phase           <= 1'b0;
         x_ovf           <= 1'b0;
         hi_byte         <= '0;
         x_cnt           <= '0;
         y_cnt           <= '0;
      end else begin
         pix.pix_valid   <= 1'b0;
         pix.line_err    <= 1'b0;
         pix.frame_start <= start_set;
         pix.frame_done  <= done_set;
         if (start_set) begin
            y_cnt     <= '0;
            pix.pix_x <= '0;
            pix.pix_y <= '0;
         end
         if (!capture_en) begin
            // also covers a vsync rise mid-line: the line is dropped silently
            phase <= 1'b0;
            x_cnt <= '0;
            x_ovf <= 1'b0;
         end else if (href) begin
            if (!phase) begin
               hi_byte <= din;
               phase   <= 1'b1;
            end else begin
               phase <= 1'b0;
               if (!y_full) begin
                  if (!x_full) begin
                     pix.pix_data  <= {hi_byte, din};
                     pix.pix_valid <= 1'b1;
                     pix.pix_x     <= x_cnt;
                     pix.pix_y     <= y_cnt;
                     x_cnt         <= x_cnt + 10'd1;
                  end else if (!x_ovf) begin
                     x_ovf        <= 1'b1;
                     pix.line_err <= 1'b1;
                  end
               end
            end
         end else if (href_fall) begin
            phase <= 1'b0;
            x_cnt <= '0;
            x_ovf <= 1'b0;
            if (!y_full) begin
               if (phase && !x_ovf) pix.line_err <= 1'b1;
               if (x_cnt != 10'd0)  y_cnt <= y_cnt + 9'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ov7670_capture.sv
// Directed bench for ov7670_capture with a small geometry (4x2, two settle frames).
// Pixels and pulses are collected by a monitor and compared against hand-computed values.
module tb_ov7670_capture;

   logic       clk, rst_n, init_done, vsync, href;
   logic [7:0] din;

   ov7670_capture_if pix_if();

   ov7670_capture #(.H_ACTIVE(4), .V_ACTIVE(2), .SETTLE_FRAMES(2)) dut (
      .clk(clk), .rst_n(rst_n), .init_done(init_done),
      .vsync(vsync), .href(href), .din(din), .pix(pix_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_fs = 0, n_fd = 0, n_le = 0;
   logic [15:0] q_d[$];
   logic [9:0]  q_x[$];
   logic [8:0]  q_y[$];
   logic [7:0]  line_buf[16];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always begin
      @(posedge clk); #1;
      if (pix_if.pix_valid) begin
         q_d.push_back(pix_if.pix_data);
         q_x.push_back(pix_if.pix_x);
         q_y.push_back(pix_if.pix_y);
      end
      if (pix_if.frame_start) n_fs++;
      if (pix_if.frame_done)  n_fd++;
      if (pix_if.line_err)    n_le++;
   end

   task automatic chk_pix(input string tag, input logic [15:0] d, input int x, input int y);
      chk({tag, "_avail"}, 64'(q_d.size() > 0), 64'd1);
      if (q_d.size() > 0) begin
         chk(tag, {q_d.pop_front(), q_x.pop_front(), q_y.pop_front()},
             {d, 10'(x), 9'(y)});
      end
   endtask

   task automatic send_line(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); href = 1'b1; din = line_buf[i];
      end
      @(negedge clk); href = 1'b0; din = 8'h00;
      repeat (3) @(negedge clk);
   endtask

   task automatic vs_low();
      @(negedge clk); vsync = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic vs_high();
      @(negedge clk); vsync = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic plain_frame();
      for (int i = 0; i < 4; i++) line_buf[i] = 8'h90 + 8'(i);
      vs_low();
      send_line(4);
      send_line(4);
      vs_high();
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_strobes"}, {pix_if.pix_valid, pix_if.frame_start, pix_if.frame_done, pix_if.line_err}, 0);
      chk({tag, "_data"}, pix_if.pix_data, 0);
      chk({tag, "_xy"}, {pix_if.pix_x, pix_if.pix_y}, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b1; init_done = 1'b0; vsync = 1'b1; href = 1'b0; din = 8'h00;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk_outs_zero("rst0");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      init_done = 1'b1;

      // two settling frames must produce nothing
      plain_frame();
      plain_frame();
      chk("settle_fs", n_fs, 0);
      chk("settle_pix", q_d.size(), 0);

      // third frame accepted; first line has an odd byte count
      vs_low();
      chk("f3_fs", n_fs, 1);
      line_buf[0] = 8'h11; line_buf[1] = 8'h22; line_buf[2] = 8'h33;
      line_buf[3] = 8'h44; line_buf[4] = 8'h55;
      send_line(5);
      chk("odd_err", n_le, 1);
      chk_pix("odd_p0", 16'h1122, 0, 0);
      chk_pix("odd_p1", 16'h3344, 1, 0);

      // RGB565 line with cycle-exact latency check
      @(negedge clk); href = 1'b1; din = 8'hF8;
      @(posedge clk); #1; chk("lat_b1", pix_if.pix_valid, 0);
      @(negedge clk); din = 8'h00;
      @(posedge clk); #1; chk("lat_b2", {pix_if.pix_valid, pix_if.pix_data, pix_if.pix_x, pix_if.pix_y},
                              {1'b1, 16'hF800, 10'd0, 9'd1});
      @(negedge clk); din = 8'h07;
      @(posedge clk); #1; chk("lat_b3", pix_if.pix_valid, 0);
      @(negedge clk); din = 8'hE0;
      @(posedge clk); #1; chk("lat_b4", {pix_if.pix_valid, pix_if.pix_data, pix_if.pix_x, pix_if.pix_y},
                              {1'b1, 16'h07E0, 10'd1, 9'd1});
      @(negedge clk); href = 1'b0; din = 8'h00;
      repeat (3) @(negedge clk);
      chk_pix("rgb_p0", 16'hF800, 0, 1);
      chk_pix("rgb_p1", 16'h07E0, 1, 1);
      chk("rgb_noerr", n_le, 1);

      // third line exceeds V_ACTIVE: suppressed without error
      send_line(4);
      chk("vfull_pix", q_d.size(), 0);
      chk("vfull_err", n_le, 1);
      vs_high();
      chk("f3_fd", n_fd, 1);

`ifdef OV7670_CAPTURE_DECIMATE_EN
      plain_frame();
      chk("skip1_fs", n_fs, 1);
      chk("skip1_fd", n_fd, 1);
      chk("skip1_pix", q_d.size(), 0);
`endif

      // overlong line then vsync rise mid-line
      vs_low();
      chk("f4_fs", n_fs, 2);
      for (int i = 0; i < 12; i++) line_buf[i] = 8'(i + 1);
      send_line(12);
      chk("long_err", n_le, 2);
      chk("long_cnt", q_d.size(), 4);
      chk_pix("long_p0", 16'h0102, 0, 0);
      chk_pix("long_p1", 16'h0304, 1, 0);
      chk_pix("long_p2", 16'h0506, 2, 0);
      chk_pix("long_p3", 16'h0708, 3, 0);
      @(negedge clk); href = 1'b1; din = 8'hA1;
      @(negedge clk); din = 8'hA2;
      @(negedge clk); din = 8'hA3;
      @(negedge clk); din = 8'hA4; vsync = 1'b1;
      @(negedge clk); href = 1'b0; din = 8'h00;
      repeat (4) @(negedge clk);
      chk("abort_fd", n_fd, 2);
      chk("abort_err", n_le, 2);
      chk("abort_cnt", q_d.size(), 1);
      chk_pix("abort_p0", 16'hA1A2, 0, 1);

`ifdef OV7670_CAPTURE_DECIMATE_EN
      plain_frame();
      chk("skip2_fs", n_fs, 2);
      chk("skip2_pix", q_d.size(), 0);
`endif

      // init_done dropped mid-pixel
      vs_low();
      chk("f5_fs", n_fs, 3);
      @(negedge clk); href = 1'b1; din = 8'hC1;
      @(negedge clk); din = 8'hC2;
      @(negedge clk); din = 8'hC3;
      @(negedge clk); din = 8'hC4; init_done = 1'b0;
      @(negedge clk); href = 1'b0; din = 8'h00;
      repeat (3) @(negedge clk);
      vs_high();
      chk("drop_cnt", q_d.size(), 1);
      chk_pix("drop_p0", 16'hC1C2, 0, 0);
      chk("drop_fd", n_fd, 2);

      // reset in the middle of an active frame
      init_done = 1'b1;
      plain_frame();
      plain_frame();
      vs_low();
      chk("f6_fs", n_fs, 4);
      @(negedge clk); href = 1'b1; din = 8'h5A;
      @(negedge clk); din = 8'h5B;
      @(negedge clk); href = 1'b0; din = 8'h00; rst_n = 1'b0; init_done = 1'b0;
      repeat (5) @(negedge clk);
      chk_outs_zero("rst1");
      chk_pix("prerst_p0", 16'h5A5B, 0, 0);
      rst_n = 1'b1;
      vs_high();
      plain_frame();
      chk("postrst_fs", n_fs, 4);
      chk("postrst_pix", q_d.size(), 0);
      chk("postrst_fd", n_fd, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
